core_ex_dmem_resp: RTL



---
 rtl/core_ex_dmem_resp_pkg.sv | 18 +
 rtl/core_dmem_sram.sv | 32 +++
 rtl/core_ex_dmem_resp.sv | 127 ++++++++++++
 3 files changed

// File: rtl/core_ex_dmem_resp_pkg.sv
// Shared constants and FSM encoding for the EXU data-memory responder.
// Default sizing matches the RV64 core's on-chip data RAM.
package core_ex_dmem_resp_pkg;

  localparam int CORE_XLEN             = 64;
  localparam int CORE_DMEM_MASK_WIDTH  = CORE_XLEN / 8;
  localparam int CORE_DMEM_ADDR_WIDTH  = 32;
  localparam int CORE_DMEM_DEPTH_LOG2  = 12;
  localparam int CORE_DMEM_LATENCY     = 1;
  localparam logic [CORE_DMEM_ADDR_WIDTH-1:0] CORE_DMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    CORE_DMEM_ST_IDLE = 2'd0,
    CORE_DMEM_ST_WAIT = 2'd1,
    CORE_DMEM_ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/core_dmem_sram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// rdata only updates on an enabled read, so it holds across stalls downstream.
module core_dmem_sram #(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [XLEN/8-1:0]     wmask,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset so it maps onto SRAM macros; non-blocking
  // assignments keep the read-before-write ordering of a real clocked RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < XLEN / 8; b++) begin
          if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/core_ex_dmem_resp.sv
// Memory end of the LSU request/response handshake: latches one request, waits a
// fixed latency, performs it on the byte-maskable SRAM and holds the response.
module core_ex_dmem_resp
  import core_ex_dmem_resp_pkg::*;
#(
  parameter int XLEN       = CORE_XLEN,
  parameter int ADDR_WIDTH = CORE_DMEM_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = CORE_DMEM_DEPTH_LOG2,
  parameter int LATENCY    = CORE_DMEM_LATENCY,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = CORE_DMEM_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wen,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [XLEN/8-1:0]     req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err
);

  localparam int CNT_W     = 4;
  localparam int OFF_SHIFT = $clog2(XLEN / 8);
  localparam int AW1       = ADDR_WIDTH + 1;
  // One extra bit so BASE + size cannot wrap at the top of the address space.
  localparam logic [AW1-1:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] LIMIT_EXT = BASE_EXT + AW1'((2 ** DEPTH_LOG2) * (XLEN / 8));

  dmem_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN/8-1:0]     wmask_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  rd_ok_q;

  logic                  accept;
  logic                  issue;
  logic                  resp_fire;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [XLEN-1:0]       sram_rdata;

  assign accept    = req_valid & req_ready;
  assign issue     = (state_q == CORE_DMEM_ST_WAIT) && (cnt_q == '0);
  assign resp_fire = resp_valid & resp_ready;

  assign in_range = ({1'b0, addr_q} >= BASE_EXT) && ({1'b0, addr_q} < LIMIT_EXT);
  assign idx      = DEPTH_LOG2'((addr_q - BASE_ADDR) >> OFF_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CORE_DMEM_ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_DMEM_ST_IDLE: if (accept)     state_d = CORE_DMEM_ST_WAIT;
      CORE_DMEM_ST_WAIT: if (issue)      state_d = CORE_DMEM_ST_RESP;
      CORE_DMEM_ST_RESP: if (resp_ready) state_d = CORE_DMEM_ST_IDLE;
      default:                           state_d = CORE_DMEM_ST_IDLE;
    endcase
  end

  // Request is captured on accept so the requester may move on immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               cnt_q <= '0;
    else if (accept)                                       cnt_q <= CNT_W'(LATENCY - 1);
    else if (state_q == CORE_DMEM_ST_WAIT && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  // rd_ok_q qualifies the SRAM read register so stores and errors return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (issue) begin
      err_q   <= ~in_range;
      rd_ok_q <= ~wen_q & in_range;
    end else if (resp_fire) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end
  end

  core_dmem_sram #(
    .XLEN       (XLEN),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .en    (issue & in_range),
    .we    (wen_q),
    .idx   (idx),
    .wmask (wmask_q),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign req_ready  = (state_q == CORE_DMEM_ST_IDLE);
  assign resp_valid = (state_q == CORE_DMEM_ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? sram_rdata : '0;

endmodule
